// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results.
// The pipeline has priority; a registered one-cycle stall lets a starving MDU head through.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  output logic [31:0] pending_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;
  logic [CW-1:0]    wait_cnt;
  logic             stall_q;

  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full, head_live, pipe_wr, push, pop, pipe_grant, stall_set;
  logic          grant_we;
  logic [4:0]    grant_addr;
  logic [31:0]   grant_data;

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
  // Live bits are cleared on pop, so a live bit always marks an occupied slot.
  assign head_live = !empty && ent_live[rd_idx];
  assign pipe_wr   = wb_we && (wb_rd != 5'd0);
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;
  assign pipe_stall = stall_q;

  always_comb begin
    pop        = 1'b0;
    pipe_grant = 1'b0;
    grant_we   = 1'b0;
    grant_addr = 5'd0;
    grant_data = 32'd0;
    if (stall_q && head_live) begin
      pop        = 1'b1;
      grant_we   = 1'b1;
      grant_addr = ent_rd[rd_idx];
      grant_data = ent_data[rd_idx];
    end else if (pipe_wr) begin
      pipe_grant = 1'b1;
      grant_we   = 1'b1;
      grant_addr = wb_rd;
      grant_data = wb_data;
    end else if (!empty) begin
      pop        = 1'b1;
      grant_we   = head_live;
      grant_addr = ent_rd[rd_idx];
      grant_data = ent_data[rd_idx];
    end
  end

  // Gate with rst_n so no write leaks out while reset is held with WB inputs active.
  assign rf_we    = grant_we && rst_n;
  assign rf_waddr = rst_n ? grant_addr : 5'd0;
  assign rf_wdata = rst_n ? grant_data : 32'd0;

  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) pending_mask[ent_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  assign stall_set = head_live && !pop && (wait_cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ent_live <= '0;
      wait_cnt <= '0;
      stall_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd[i]   <= 5'd0;
        ent_data[i] <= 32'd0;
      end
    end else begin
      if (pipe_grant) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_rd[i] == wb_rd) ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_live[rd_idx] <= 1'b0;
        rd_ptr           <= rd_ptr + (AW+1)'(1);
      end
      // The push slot is never the popped slot, so these writes cannot collide.
      if (push) begin
        ent_rd[wr_idx]   <= mdu_rd;
        ent_data[wr_idx] <= mdu_data;
        ent_live[wr_idx] <= (mdu_rd != 5'd0) && !(pipe_grant && (wb_rd == mdu_rd));
        wr_ptr           <= wr_ptr + (AW+1)'(1);
      end
      if (pop || !head_live) wait_cnt <= '0;
      else if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + CW'(1);
      stall_q <= stall_set;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: priority, kill, starvation stall, x0 and reset.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_pass   = 0;

  wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for the current cycle, then let combinational outputs settle.
  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_we = we; wb_rd = rd; wb_data = d;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_ready", {31'd0, mdu_ready}, 32'd1);
    check("rst_mask", pending_mask, 32'd0);
    check("rst_stall", {31'd0, pipe_stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain pipeline write with the FIFO idle.
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    check("t1_we", {31'd0, rf_we}, 32'd1);
    check("t1_addr", {27'd0, rf_waddr}, 32'd5);
    check("t1_data", rf_wdata, 32'hA5A5A5A5);
    check("t1_stall", {31'd0, pipe_stall}, 32'd0);
    tick();

    // MDU result drained into the next idle slot.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    check("t2_enq_we", {31'd0, rf_we}, 32'd0);
    check("t2_enq_mask", pending_mask, 32'd0);
    tick();
    idle();
    check("t2_mask7", pending_mask, 32'h0000_0080);
    check("t2_we", {31'd0, rf_we}, 32'd1);
    check("t2_addr", {27'd0, rf_waddr}, 32'd7);
    check("t2_data", rf_wdata, 32'h1234);
    tick();
    check("t2_mask_clr", pending_mask, 32'd0);
    check("t2_idle_we", {31'd0, rf_we}, 32'd0);

    // Kill: pipeline write to rd 9 supersedes the buffered MDU value.
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'hDEAD);
    check("t3_pipe_addr", {27'd0, rf_waddr}, 32'd4);
    tick();
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    check("t3_mask9", pending_mask, 32'h0000_0200);
    check("t3_we", {31'd0, rf_we}, 32'd1);
    check("t3_addr", {27'd0, rf_waddr}, 32'd9);
    check("t3_data", rf_wdata, 32'h55);
    tick();
    idle();
    check("t3_dead_mask", pending_mask, 32'd0);
    check("t3_dead_we", {31'd0, rf_we}, 32'd0);
    tick();
    check("t3_empty_we", {31'd0, rf_we}, 32'd0);

    // Same-cycle enqueue to the rd being written by the pipeline is enqueued dead.
    drive(1'b1, 5'd12, 32'h66, 1'b1, 5'd12, 32'hBAD);
    check("t3b_addr", {27'd0, rf_waddr}, 32'd12);
    check("t3b_data", rf_wdata, 32'h66);
    tick();
    idle();
    check("t3b_mask", pending_mask, 32'd0);
    check("t3b_we", {31'd0, rf_we}, 32'd0);
    tick();

    // Starvation: two entries, pipeline writes x3 every cycle.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'h1010);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'h1111);
    check("t4_ready1", {31'd0, mdu_ready}, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
      check($sformatf("t4_blk%0d_stall", c), {31'd0, pipe_stall}, 32'd0);
      check($sformatf("t4_blk%0d_addr", c), {27'd0, rf_waddr}, 32'd3);
      if (c > 1) check($sformatf("t4_blk%0d_full", c), {31'd0, mdu_ready}, 32'd0);
      tick();
    end
    check("t4_stall", {31'd0, pipe_stall}, 32'd1);
    check("t4_st_we", {31'd0, rf_we}, 32'd1);
    check("t4_st_addr", {27'd0, rf_waddr}, 32'd10);
    check("t4_st_data", rf_wdata, 32'h1010);
    check("t4_st_mask", pending_mask, 32'h0000_0C00);
    tick();
    check("t4_unstall", {31'd0, pipe_stall}, 32'd0);
    check("t4_resume_addr", {27'd0, rf_waddr}, 32'd3);
    check("t4_ready2", {31'd0, mdu_ready}, 32'd1);
    check("t4_mask11", pending_mask, 32'h0000_0800);
    tick();
    idle();
    check("t4_drain_addr", {27'd0, rf_waddr}, 32'd11);
    check("t4_drain_data", rf_wdata, 32'h1111);
    check("t4_drain_stall", {31'd0, pipe_stall}, 32'd0);
    tick();
    check("t4_mask_clr", pending_mask, 32'd0);

    // x0 destination: never written, never pending.
    drive(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'hFFFF);
    check("t5_we", {31'd0, rf_we}, 32'd0);
    check("t5_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    idle();
    check("t5_mask", pending_mask, 32'd0);
    check("t5_dead_we", {31'd0, rf_we}, 32'd0);
    check("t5_ready2", {31'd0, mdu_ready}, 32'd1);
    tick();

    // Reset mid-operation with a full FIFO and the stall raised.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h2020);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd21, 32'h2121);
    tick();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    repeat (7) tick();
    check("t6_pre_stall", {31'd0, pipe_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_we", {31'd0, rf_we}, 32'd0);
    check("t6_rst_stall", {31'd0, pipe_stall}, 32'd0);
    check("t6_rst_mask", pending_mask, 32'd0);
    check("t6_rst_ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("t6_post%0d_we", c), {31'd0, rf_we}, 32'd0);
      check($sformatf("t6_post%0d_mask", c), pending_mask, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
